// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I-subset control decoder: opcodes and the
// select/operation codes driven onto the datapath.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } result_src_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_TARGET = 2'b01,
    PC_ALU    = 2'b10
  } pc_src_t;

endpackage

// File: rtl/riscv_control_unit_if.sv
// Instruction/flag inputs and datapath control outputs of the decoder.
interface riscv_control_unit_if;

  logic [31:0] Instr;
  logic        Zero;
  logic [1:0]  PCSrc;
  logic [1:0]  ResultSrc;
  logic        MemWrite;
  logic        ALUSrc;
  logic        RegWrite;
  logic [2:0]  ALUControl;
  logic [2:0]  ImmSrc;
  logic        Illegal;
  logic        IllegalSeen;

  modport master (
    output Instr, Zero,
    input  PCSrc, ResultSrc, MemWrite, ALUSrc, RegWrite,
    input  ALUControl, ImmSrc, Illegal, IllegalSeen
  );

  modport slave (
    input  Instr, Zero,
    output PCSrc, ResultSrc, MemWrite, ALUSrc, RegWrite,
    output ALUControl, ImmSrc, Illegal, IllegalSeen
  );

endinterface

// File: rtl/riscv_alu_decoder.sv
// Maps the main decoder's ALUOp plus funct fields to an ALU operation;
// flags funct3 values this core does not implement.
module riscv_alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_t     alu_op,
  input  logic [2:0]  funct3,
  input  logic        op5,
  input  logic        funct7b5,
  output alu_ctrl_t   alu_control,
  output logic        illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type from I-type so addi never becomes sub
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: begin
            alu_control = ALU_ADD;
            illegal     = 1'b1;
          end
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_control_unit.sv
// Single-cycle RV32I-subset control unit: combinational main decode, ALU
// decode sub-block, and a sticky illegal-instruction status flag.
module riscv_control_unit
  import riscv_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  riscv_control_unit_if.slave   ctrl
);

  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        unused_instr;

  logic        reg_write_dec;
  logic        mem_write_dec;
  logic        alu_src;
  imm_src_t    imm_src;
  result_src_t result_src;
  alu_op_t     alu_op;
  pc_src_t     pc_src_dec;
  logic        op_illegal;

  alu_ctrl_t   alu_control;
  logic        alu_illegal;
  logic        illegal;
  logic        illegal_seen_reg;

  assign op           = ctrl.Instr[6:0];
  assign funct3       = ctrl.Instr[14:12];
  assign funct7b5     = ctrl.Instr[30];
  assign unused_instr = ^{ctrl.Instr[31], ctrl.Instr[29:15], ctrl.Instr[11:7]};

  always_comb begin
    reg_write_dec = 1'b0;
    mem_write_dec = 1'b0;
    alu_src       = 1'b0;
    imm_src       = IMM_I;
    result_src    = RES_ALU;
    alu_op        = ALUOP_ADD;
    pc_src_dec    = PC_PLUS4;
    op_illegal    = 1'b0;
    case (op)
      OP_RTYPE: begin
        reg_write_dec = 1'b1;
        alu_op        = ALUOP_FUNCT;
      end
      OP_IALU: begin
        reg_write_dec = 1'b1;
        alu_src       = 1'b1;
        alu_op        = ALUOP_FUNCT;
      end
      OP_LOAD: begin
        reg_write_dec = 1'b1;
        alu_src       = 1'b1;
        result_src    = RES_MEM;
      end
      OP_STORE: begin
        imm_src       = IMM_S;
        alu_src       = 1'b1;
        mem_write_dec = 1'b1;
      end
      OP_BEQ: begin
        imm_src    = IMM_B;
        alu_op     = ALUOP_SUB;
        pc_src_dec = ctrl.Zero ? PC_TARGET : PC_PLUS4;
      end
      OP_JAL: begin
        reg_write_dec = 1'b1;
        imm_src       = IMM_J;
        result_src    = RES_PC4;
        pc_src_dec    = PC_TARGET;
      end
      OP_JALR: begin
        reg_write_dec = 1'b1;
        alu_src       = 1'b1;
        result_src    = RES_PC4;
        pc_src_dec    = PC_ALU;
      end
      OP_LUI: begin
        reg_write_dec = 1'b1;
        imm_src       = IMM_U;
        result_src    = RES_IMM;
      end
      default: op_illegal = 1'b1;
    endcase
  end

  riscv_alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_control),
    .illegal     (alu_illegal)
  );

  assign illegal = op_illegal | alu_illegal;

  // State-changing controls are held off while reset is asserted
  assign ctrl.RegWrite    = rst_n & reg_write_dec;
  assign ctrl.MemWrite    = rst_n & mem_write_dec;
  assign ctrl.PCSrc       = rst_n ? pc_src_dec : PC_PLUS4;
  assign ctrl.ALUSrc      = alu_src;
  assign ctrl.ImmSrc      = imm_src;
  assign ctrl.ResultSrc   = result_src;
  assign ctrl.ALUControl  = alu_control;
  assign ctrl.Illegal     = illegal;
  assign ctrl.IllegalSeen = illegal_seen_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_seen_reg <= 1'b0;
    end else if (illegal) begin
      illegal_seen_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_control_unit.sv
// Directed test-plan vectors followed by randomized instructions, checked
// against a table-driven reference model of the decode rules.
module tb_riscv_control_unit;

  logic clk;
  logic rst_n;

  riscv_control_unit_if cif ();

  riscv_control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;

  // {op, RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, ALUOp, jump PCSrc}
  logic [18:0] tbl [8] = '{
    {7'b0110011, 1'b1, 3'b000, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00},
    {7'b0010011, 1'b1, 3'b000, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00},
    {7'b0000011, 1'b1, 3'b000, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00},
    {7'b0100011, 1'b0, 3'b001, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00},
    {7'b1100011, 1'b0, 3'b010, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00},
    {7'b1101111, 1'b1, 3'b011, 1'b0, 1'b0, 2'b10, 2'b00, 2'b01},
    {7'b1100111, 1'b1, 3'b000, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10},
    {7'b0110111, 1'b1, 3'b100, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00}
  };

  logic       e_rw, e_asrc, e_mw, e_ill, e_seen;
  logic [2:0] e_imm, e_alu;
  logic [1:0] e_res, e_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic [31:0] instr, input logic zero, input logic rst);
    logic [6:0] op;
    logic [2:0] f3;
    logic [1:0] aop;
    logic [1:0] jmp;
    logic       found;
    op = instr[6:0];
    f3 = instr[14:12];
    found = 1'b0;
    {e_rw, e_imm, e_asrc, e_mw, e_res, aop, jmp} = '0;
    foreach (tbl[k]) begin
      if (tbl[k][18:12] == op) begin
        found = 1'b1;
        {e_rw, e_imm, e_asrc, e_mw, e_res, aop, jmp} = tbl[k][11:0];
      end
    end
    e_ill = !found;
    e_pc  = (op == 7'b1100011) ? {1'b0, zero} : jmp;
    e_alu = 3'b000;
    if (aop == 2'b01) e_alu = 3'b001;
    if (aop == 2'b10) begin
      if (f3 == 3'd0)      e_alu = (op[5] && instr[30]) ? 3'b001 : 3'b000;
      else if (f3 == 3'd2) e_alu = 3'b101;
      else if (f3 == 3'd6) e_alu = 3'b011;
      else if (f3 == 3'd7) e_alu = 3'b010;
      else                 e_ill = 1'b1;
    end
    if (!rst) begin
      e_rw = 1'b0;
      e_mw = 1'b0;
      e_pc = 2'b00;
    end
  endtask

  // Called just after a falling edge: drive, check mid-cycle, then clock it
  task automatic apply(input logic [31:0] instr, input logic zero, input logic rst);
    cif.Instr = instr;
    cif.Zero  = zero;
    rst_n     = rst;
    if (!rst) e_seen = 1'b0;
    model(instr, zero, rst);
    #2;
    $display("vec instr=%08h zero=%0b rst_n=%0b", instr, zero, rst);
    check("RegWrite",    {31'd0, cif.RegWrite},    {31'd0, e_rw});
    check("MemWrite",    {31'd0, cif.MemWrite},    {31'd0, e_mw});
    check("ALUSrc",      {31'd0, cif.ALUSrc},      {31'd0, e_asrc});
    check("ImmSrc",      {29'd0, cif.ImmSrc},      {29'd0, e_imm});
    check("ResultSrc",   {30'd0, cif.ResultSrc},   {30'd0, e_res});
    check("PCSrc",       {30'd0, cif.PCSrc},       {30'd0, e_pc});
    check("ALUControl",  {29'd0, cif.ALUControl},  {29'd0, e_alu});
    check("Illegal",     {31'd0, cif.Illegal},     {31'd0, e_ill});
    check("IllegalSeen", {31'd0, cif.IllegalSeen}, {31'd0, e_seen});
    @(posedge clk);
    if (rst && e_ill) e_seen = 1'b1;
    #1;
    check("IllegalSeen_edge", {31'd0, cif.IllegalSeen}, {31'd0, e_seen});
    @(negedge clk);
  endtask

  logic [6:0] legal_ops [8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37};

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    e_seen    = 1'b0;
    cif.Instr = 32'h0000_0033;
    cif.Zero  = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    apply(32'h0000_0023, 1'b0, 1'b0);
    apply(32'h0000_0033, 1'b1, 1'b1);
    apply(32'h4000_0033, 1'b0, 1'b1);
    apply(32'h0000_6033, 1'b0, 1'b1);
    apply(32'h0000_7033, 1'b0, 1'b1);
    apply(32'h0000_2033, 1'b0, 1'b1);
    apply(32'h4000_0013, 1'b0, 1'b1);
    apply(32'h0000_2003, 1'b0, 1'b1);
    apply(32'h0000_2023, 1'b0, 1'b1);
    apply(32'h0000_0063, 1'b0, 1'b1);
    apply(32'h0000_0063, 1'b1, 1'b1);
    apply(32'h0000_006F, 1'b0, 1'b1);
    apply(32'h0000_0067, 1'b0, 1'b1);
    apply(32'h0000_0037, 1'b0, 1'b1);
    apply(32'h0000_007F, 1'b0, 1'b1);
    apply(32'h0000_0033, 1'b0, 1'b1);
    apply(32'h0000_1033, 1'b0, 1'b1);
    // Mid-cycle reset must clear the sticky flag without a clock edge
    apply(32'h0000_2023, 1'b1, 1'b0);
    apply(32'h0000_0033, 1'b0, 1'b1);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] instr;
      instr = $urandom;
      if ($urandom_range(0, 4) != 0) instr[6:0] = legal_ops[$urandom_range(0, 7)];
      apply(instr, 1'($urandom_range(0, 1)), ($urandom_range(0, 24) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
